// File: rtl/pp_csa_tree_pkg.sv
// Shared MAC parameters: mantissa width, Booth partial-product count and width.
// The Booth generator and the carry-save tree both take their sizing from here.
package pp_csa_tree_pkg;

    localparam int MAC_MANT_W = 23;
    localparam int MAC_PP_CNT = MAC_MANT_W / 2 + 2;
    localparam int MAC_PP_W   = 2 * MAC_MANT_W + 3;
    localparam int MAC_S1_CNT = 6;

endpackage

// File: rtl/pp_csa_tree_csa32.sv
// Bitwise 3:2 carry-save compressor.
// The carry output is already weight-aligned: shifted left by one, with the MSB dropped.
module pp_csa_tree_csa32 #(
    parameter int W = 49
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/pp_csa_tree.sv
// Two-stage pipelined 13:2 carry-save reduction of Booth partial products.
// The tree is 13->9->6 | reg | ->4->3->2 | reg, with valid/ready handshake on both sides.
module pp_csa_tree
    import pp_csa_tree_pkg::*;
#(
    parameter int PARM_MANT = MAC_MANT_W,
    parameter int PARM_PP   = MAC_PP_CNT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2*PARM_MANT+2:0] pp_00_i,
    input  logic [2*PARM_MANT+2:0] pp_01_i,
    input  logic [2*PARM_MANT+2:0] pp_02_i,
    input  logic [2*PARM_MANT+2:0] pp_03_i,
    input  logic [2*PARM_MANT+2:0] pp_04_i,
    input  logic [2*PARM_MANT+2:0] pp_05_i,
    input  logic [2*PARM_MANT+2:0] pp_06_i,
    input  logic [2*PARM_MANT+2:0] pp_07_i,
    input  logic [2*PARM_MANT+2:0] pp_08_i,
    input  logic [2*PARM_MANT+2:0] pp_09_i,
    input  logic [2*PARM_MANT+2:0] pp_10_i,
    input  logic [2*PARM_MANT+2:0] pp_11_i,
    input  logic [2*PARM_MANT+2:0] pp_12_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [2*PARM_MANT+2:0] sum_o,
    output logic [2*PARM_MANT+2:0] carry_o
);

    localparam int W = 2 * PARM_MANT + 3;

    logic [W-1:0] l0_s [PARM_PP];
    logic [W-1:0] l1_s [9];
    logic [W-1:0] l2_s [MAC_S1_CNT];
    logic [W-1:0] s1_data_r [MAC_S1_CNT];
    logic [W-1:0] l3_s [4];
    logic [W-1:0] l4_s [3];
    logic [W-1:0] l5_sum_s;
    logic [W-1:0] l5_carry_s;
    logic [W-1:0] s2_sum_r;
    logic [W-1:0] s2_carry_r;
    logic         s1_valid_r;
    logic         s2_valid_r;
    logic         s2_adv_s;
    logic         s1_adv_s;
    logic         in_xfer_s;

    assign l0_s[0]  = pp_00_i;
    assign l0_s[1]  = pp_01_i;
    assign l0_s[2]  = pp_02_i;
    assign l0_s[3]  = pp_03_i;
    assign l0_s[4]  = pp_04_i;
    assign l0_s[5]  = pp_05_i;
    assign l0_s[6]  = pp_06_i;
    assign l0_s[7]  = pp_07_i;
    assign l0_s[8]  = pp_08_i;
    assign l0_s[9]  = pp_09_i;
    assign l0_s[10] = pp_10_i;
    assign l0_s[11] = pp_11_i;
    assign l0_s[12] = pp_12_i;

    // Level 1 (13->9): four compressors, the 13th operand passes straight through.
    for (genvar i = 0; i < 4; i++) begin : g_lvl1
        pp_csa_tree_csa32 #(.W(W)) u_csa (
            .a(l0_s[3*i]), .b(l0_s[3*i+1]), .c(l0_s[3*i+2]),
            .sum(l1_s[2*i]), .carry(l1_s[2*i+1])
        );
    end
    assign l1_s[8] = l0_s[12];

    for (genvar i = 0; i < 3; i++) begin : g_lvl2
        pp_csa_tree_csa32 #(.W(W)) u_csa (
            .a(l1_s[3*i]), .b(l1_s[3*i+1]), .c(l1_s[3*i+2]),
            .sum(l2_s[2*i]), .carry(l2_s[2*i+1])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_lvl3
        pp_csa_tree_csa32 #(.W(W)) u_csa (
            .a(s1_data_r[3*i]), .b(s1_data_r[3*i+1]), .c(s1_data_r[3*i+2]),
            .sum(l3_s[2*i]), .carry(l3_s[2*i+1])
        );
    end

    // Level 4 (4->3): the fourth vector passes through.
    pp_csa_tree_csa32 #(.W(W)) u_lvl4 (
        .a(l3_s[0]), .b(l3_s[1]), .c(l3_s[2]),
        .sum(l4_s[0]), .carry(l4_s[1])
    );
    assign l4_s[2] = l3_s[3];

    pp_csa_tree_csa32 #(.W(W)) u_lvl5 (
        .a(l4_s[0]), .b(l4_s[1]), .c(l4_s[2]),
        .sum(l5_sum_s), .carry(l5_carry_s)
    );

    assign s2_adv_s  = ~s2_valid_r | ready_i;
    assign s1_adv_s  = s1_valid_r & s2_adv_s;
    assign ready_o   = ~s1_valid_r | s2_adv_s;
    assign in_xfer_s = valid_i & ready_o;

    // Occupancy flags; reset drops any set in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (in_xfer_s) begin
                s1_valid_r <= 1'b1;
            end else if (s1_adv_s) begin
                s1_valid_r <= 1'b0;
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
            end
        end
    end

    // Stage S1 data loads only on an accepted input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAC_S1_CNT; i++) begin
                s1_data_r[i] <= '0;
            end
        end else if (in_xfer_s) begin
            for (int i = 0; i < MAC_S1_CNT; i++) begin
                s1_data_r[i] <= l2_s[i];
            end
        end
    end

    // Stage S2 data loads only when S1 hands over, so a stalled result stays put.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_sum_r   <= '0;
            s2_carry_r <= '0;
        end else if (s1_adv_s) begin
            s2_sum_r   <= l5_sum_s;
            s2_carry_r <= l5_carry_s;
        end
    end

    assign valid_o = s2_valid_r;
    assign sum_o   = s2_sum_r;
    assign carry_o = s2_carry_r;

endmodule

// File: tb/tb_pp_csa_tree.sv
// Bench for pp_csa_tree: Booth partial products are built arithmetically from mantissa
// pairs, and a queue of expected products tracks every accepted set.
module tb_pp_csa_tree;

    localparam int W = 49;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] prod;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic          ready_i;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  pp_drv [13];
    logic [W-1:0]  sum_o;
    logic [W-1:0]  carry_o;
    int            errors = 0;
    int            checks = 0;
    logic [47:0]   exp_q [$];
    vec_t          tbl [7];

    always #5 clk = ~clk;

    pp_csa_tree dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .pp_00_i(pp_drv[0]), .pp_01_i(pp_drv[1]), .pp_02_i(pp_drv[2]),
        .pp_03_i(pp_drv[3]), .pp_04_i(pp_drv[4]), .pp_05_i(pp_drv[5]),
        .pp_06_i(pp_drv[6]), .pp_07_i(pp_drv[7]), .pp_08_i(pp_drv[8]),
        .pp_09_i(pp_drv[9]), .pp_10_i(pp_drv[10]), .pp_11_i(pp_drv[11]),
        .pp_12_i(pp_drv[12]),
        .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .carry_o(carry_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Radix-4 Booth digits of the zero-extended multiplier, each digit*A shifted into place.
    task automatic load_pps(input logic [23:0] a, input logic [23:0] b);
        logic [26:0] be;
        int          d;
        longint      p;
        logic [63:0] pu;
        be = {2'b00, b, 1'b0};
        for (int i = 0; i < 13; i++) begin
            d = -2 * int'(be[2*i+2]) + int'(be[2*i+1]) + int'(be[2*i]);
            p = longint'(d) * longint'(a);
            p = p <<< (2 * i);
            pu = p;
            pp_drv[i] = pu[W-1:0];
        end
    endtask

    task automatic cycle(input bit v, input bit r, input logic [23:0] a, input logic [23:0] b,
                         input logic [47:0] prod, output bit acc);
        logic [W-1:0] tot;
        valid_i = v;
        ready_i = r;
        load_pps(a, b);
        #1;
        acc = valid_i && ready_o;
        check("ready_o", {63'd0, ready_o}, (exp_q.size() == 2 && !r) ? 64'd0 : 64'd1);
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got valid_o=1, required no pending set");
            end else begin
                tot = sum_o + carry_o;
                check("product", {16'd0, tot[47:0]}, {16'd0, exp_q.pop_front()});
            end
        end
        if (acc) begin
            exp_q.push_back(prod);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        logic [23:0] a;
        logic [23:0] b;
        logic [W-1:0] hold_sum;
        logic [W-1:0] hold_carry;
        int          n_acc;
        int          cyc;

        tbl[0] = '{24'h800000, 24'h800000, 48'h400000000000};
        tbl[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
        tbl[2] = '{24'h000000, 24'hABCDEF, 48'h000000000000};
        tbl[3] = '{24'hFFFFFF, 24'h000001, 48'h000000FFFFFF};
        tbl[4] = '{24'h000002, 24'h800000, 48'h000001000000};
        tbl[5] = '{24'h123456, 24'h000010, 48'h000001234560};
        tbl[6] = '{24'hFFFFFF, 24'h800000, 48'h7FFFFF800000};

        // Reset state
        rst = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        load_pps(24'd0, 24'd0);
        #1;
        check("rst_valid_o", {63'd0, valid_o}, 64'd0);
        check("rst_sum_o", {15'd0, sum_o}, 64'd0);
        check("rst_carry_o", {15'd0, carry_o}, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_ready_o", {63'd0, ready_o}, 64'd1);

        // Table vectors, one at a time: 2-cycle latency and exact product
        foreach (tbl[k]) begin
            cycle(1'b1, 1'b1, tbl[k].a, tbl[k].b, tbl[k].prod, acc);
            check("tbl_accept", {63'd0, acc}, 64'd1);
            check("tbl_lat1_valid", {63'd0, valid_o}, 64'd0);
            cycle(1'b0, 1'b1, 24'd0, 24'd0, 48'd0, acc);
            check("tbl_lat2_valid", {63'd0, valid_o}, 64'd1);
            cycle(1'b0, 1'b1, 24'd0, 24'd0, 48'd0, acc);
            check("tbl_drain_valid", {63'd0, valid_o}, 64'd0);
        end

        // 20 back-to-back sets with ready_i high
        for (int t = 0; t < 23; t++) begin
            check("b2b_valid_o", {63'd0, valid_o}, (t >= 2 && t <= 21) ? 64'd1 : 64'd0);
            a = 24'($urandom);
            b = 24'($urandom);
            cycle(t < 20, 1'b1, a, b, {24'd0, a} * {24'd0, b}, acc);
        end

        // Downstream stall for 5 cycles with continuous input
        n_acc = 0;
        a = 24'($urandom);
        b = 24'($urandom);
        for (int t = 0; t < 5; t++) begin
            check("stall_valid_o", {63'd0, valid_o}, (t >= 2) ? 64'd1 : 64'd0);
            if (t == 2) begin
                hold_sum = sum_o;
                hold_carry = carry_o;
            end else if (t > 2) begin
                check("stall_sum_stable", {15'd0, sum_o}, {15'd0, hold_sum});
                check("stall_carry_stable", {15'd0, carry_o}, {15'd0, hold_carry});
            end
            cycle(1'b1, 1'b0, a, b, {24'd0, a} * {24'd0, b}, acc);
            if (acc) begin
                n_acc++;
                a = 24'($urandom);
                b = 24'($urandom);
            end
        end
        check("stall_accepted", 64'(n_acc), 64'd2);
        for (int t = 0; t < 4; t++) begin
            cycle(1'b0, 1'b1, 24'd0, 24'd0, 48'd0, acc);
        end
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full
        for (int t = 0; t < 2; t++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            cycle(1'b1, 1'b0, a, b, {24'd0, a} * {24'd0, b}, acc);
        end
        check("rst_mid_full", {63'd0, valid_o}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid_o", {63'd0, valid_o}, 64'd0);
        check("rst_mid_sum_o", {15'd0, sum_o}, 64'd0);
        check("rst_mid_carry_o", {15'd0, carry_o}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ready_o", {63'd0, ready_o}, 64'd1);
        for (int t = 0; t < 3; t++) begin
            cycle(1'b0, 1'b1, 24'd0, 24'd0, 48'd0, acc);
            check("rst_no_stale", {63'd0, valid_o}, 64'd0);
        end

        // Random handshake over 10k sets
        n_acc = 0;
        cyc = 0;
        a = 24'($urandom);
        b = 24'($urandom);
        while (n_acc < 10000 && cyc < 40000) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a, b,
                  {24'd0, a} * {24'd0, b}, acc);
            cyc++;
            if (acc) begin
                n_acc++;
                a = 24'($urandom);
                b = 24'($urandom);
            end
        end
        check("rand_accepted", 64'(n_acc), 64'd10000);
        for (int t = 0; t < 5; t++) begin
            cycle(1'b0, 1'b1, 24'd0, 24'd0, 48'd0, acc);
        end
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pp_csa_tree.md
PP_CSA_TREE -- requirements
Module: pp_csa_tree

Interface
REQ-001 SHALL have parameter PARM_MANT, default 23, mantissa width excluding the hidden bit.
REQ-002 SHALL have parameter PARM_PP, default 13, number of partial products (= PARM_MANT/2 + 2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state rises on posedge clk_i.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  partial-product set on pp_*_i is valid.
REQ-006 SHALL have port ready_o  output  1  block accepts the set this cycle.
REQ-007 SHALL have ports pp_00_i .. pp_12_i  input  2*PARM_MANT+3 (49) each  Radix-4 Booth partial products, already shifted, with sign-extension constants and negation bits included.
REQ-008 SHALL have port valid_o  output  1  sum_o/carry_o hold a valid redundant result.
REQ-009 SHALL have port ready_i  input  1  downstream accepts the result this cycle.
REQ-010 SHALL have port sum_o  output  49  redundant sum vector.
REQ-011 SHALL have port carry_o  output  49  redundant carry vector, already aligned (weight-shifted).

Function
REQ-012 SHALL reduce 13 operands to 2 with 3:2 carry-save levels: 13->9->6->4->3->2 (5 levels).
REQ-013 SHALL register after level 2 (6 vectors, stage S1) and after level 5 (2 vectors, stage S2).
REQ-014 SHALL compute all vectors modulo 2^49; carry bits shifted out of bit 48 are discarded.
REQ-015 SHALL guarantee (sum_o + carry_o) mod 2^48 == MantA*MantB for the unsigned 24-bit mantissas that generated the partial products.
REQ-016 SHALL transfer an input when valid_i && ready_o, and an output when valid_o && ready_i.
REQ-017 SHALL drive ready_o = ~s1_valid | s2_adv, where s2_adv = ~s2_valid | ready_i (combinational, no dependency on valid_i).
REQ-018 SHALL advance S1->S2 when s1_valid && s2_adv; S2 is cleared when it drains with no refill.
REQ-019 SHALL have a latency of 2 cycles from input acceptance to valid_o with ready_i held high.
REQ-020 SHALL sustain a throughput of 1 set per cycle with ready_i held high, with no bubbles.
REQ-021 SHALL hold sum_o, carry_o and valid_o stable while valid_o && ~ready_i.
REQ-022 SHALL never drop or duplicate a set under any valid_i/ready_i pattern; order is preserved.
REQ-023 SHALL not load data registers on cycles without a transfer; valid flags alone gate occupancy.
REQ-024 SHALL, on simultaneous S2 drain and S1 advance, load S2 with the new S1 data in the same cycle.

Reset
REQ-025 SHALL, while rst_i is high, clear s1_valid and s2_valid immediately (asynchronously), giving valid_o = 0.
REQ-026 SHALL reset sum_o and carry_o to 0, and all S1 data registers to 0.
REQ-027 SHALL discard any in-flight sets when reset is asserted mid-operation; ready_o = 1 on the first cycle after release.

Structure
REQ-028 SHALL take PARM_MANT, PARM_PP and the derived PP width (2*PARM_MANT+3) from the shared MAC parameter package shared with the Booth generator.
REQ-029 SHALL instantiate a single bitwise 3:2 compressor sub-module, CSA32 (inputs a, b, c; outputs sum, carry with carry pre-shifted left 1, MSB dropped), for every level.
REQ-030 SHALL pass the leftover operands of a level that does not fill a full triple straight through to the next level.

Verification
REQ-031 SHALL check: PPs from MantA=MantB=0x800000, ready_i=1 -> valid_o 2 cycles later; (sum_o+carry_o) mod 2^48 = 0x400000000000.
REQ-032 SHALL check: PPs from MantA=MantB=0xFFFFFF -> (sum_o+carry_o) mod 2^48 = 0xFFFFFE000001.
REQ-033 SHALL check: 20 back-to-back random sets with ready_i=1 -> 20 consecutive valid_o cycles, each matching the reference product, in order.
REQ-034 SHALL check: ready_i=0 for 5 cycles with valid_i=1 -> ready_o drops after 2 sets are held; outputs are stable; on release both sets emerge in order with none lost.
REQ-035 SHALL check: rst_i asserted mid-stream with both stages full -> valid_o=0 and sum_o=carry_o=0 immediately; ready_o=1 after release; no stale outputs.
REQ-036 SHALL check: random valid_i/ready_i toggling over 10k sets -> scoreboard matches A*B for every set, with no loss or duplication.
